// File: rtl/dcache_pkg.sv
// Shared types and constants for the direct-mapped write-back L1 data cache.
package dcache_pkg;

  localparam int unsigned NUM_LINES  = 16;
  localparam int unsigned LINE_BITS  = 256;
  localparam int unsigned ADDR_W     = 32;
  localparam int unsigned WORD_W     = 32;
  localparam int unsigned OFFSET_W   = 5;
  localparam int unsigned INDEX_W    = 4;
  localparam int unsigned TAG_W      = 23;
  localparam int unsigned WORD_SEL_W = 3;

  typedef enum logic [1:0] {
    IDLE        = 2'd0,
    WRITEBACK   = 2'd1,
    FILL        = 2'd2,
    REFILL_DONE = 2'd3
  } state_e;

  // Line-aligned byte address from a tag and an index.
  function automatic logic [ADDR_W-1:0] line_addr(input logic [TAG_W-1:0]   tag,
                                                  input logic [INDEX_W-1:0] idx);
    return {tag, idx, OFFSET_W'(0)};
  endfunction

endpackage

// File: rtl/dcache_sram.sv
// Cache storage: valid/dirty/tag/data per line, combinational read, edge write of a line or a word.
module dcache_sram
  import dcache_pkg::*;
(
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [INDEX_W-1:0]    rd_idx_i,
  output logic                  rd_valid_o,
  output logic                  rd_dirty_o,
  output logic [TAG_W-1:0]      rd_tag_o,
  output logic [LINE_BITS-1:0]  rd_line_o,
  input  logic [INDEX_W-1:0]    wr_idx_i,
  input  logic                  fill_we_i,
  input  logic [TAG_W-1:0]      fill_tag_i,
  input  logic [LINE_BITS-1:0]  fill_line_i,
  input  logic                  word_we_i,
  input  logic [WORD_SEL_W-1:0] word_sel_i,
  input  logic [WORD_W-1:0]     word_data_i
);

  logic [NUM_LINES-1:0] valid_q;
  logic [NUM_LINES-1:0] dirty_q;
  logic [TAG_W-1:0]     tag_q  [NUM_LINES];
  logic [LINE_BITS-1:0] data_q [NUM_LINES];

  // Status bits are the only state that reset has to clear.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      valid_q <= '0;
      dirty_q <= '0;
    end else if (fill_we_i) begin
      valid_q[wr_idx_i] <= 1'b1;
      dirty_q[wr_idx_i] <= 1'b0;
    end else if (word_we_i) begin
      dirty_q[wr_idx_i] <= 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (fill_we_i) begin
      tag_q[wr_idx_i]  <= fill_tag_i;
      data_q[wr_idx_i] <= fill_line_i;
    end else if (word_we_i) begin
      data_q[wr_idx_i][{word_sel_i, 5'b0} +: WORD_W] <= word_data_i;
    end
  end

  assign rd_valid_o = valid_q[rd_idx_i];
  assign rd_dirty_o = dirty_q[rd_idx_i];
  assign rd_tag_o   = tag_q[rd_idx_i];
  assign rd_line_o  = data_q[rd_idx_i];

endmodule

// File: rtl/dcache_controller.sv
// Direct-mapped write-back/write-allocate L1 D-cache: hit path, miss FSM and memory handshake.
module dcache_controller
  import dcache_pkg::*;
(
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 cpu_req_i,
  input  logic                 cpu_we_i,
  input  logic [ADDR_W-1:0]    cpu_addr_i,
  input  logic [WORD_W-1:0]    cpu_wdata_i,
  output logic [WORD_W-1:0]    cpu_rdata_o,
  output logic                 cpu_stall_o,
  output logic                 mem_enable_o,
  output logic                 mem_write_o,
  output logic [ADDR_W-1:0]    mem_addr_o,
  output logic [LINE_BITS-1:0] mem_wdata_o,
  input  logic [LINE_BITS-1:0] mem_rdata_i,
  input  logic                 mem_ack_i
);

  logic [TAG_W-1:0]      cpu_tag;
  logic [INDEX_W-1:0]    cpu_idx;
  logic [WORD_SEL_W-1:0] cpu_sel;
  logic                  unused_addr_c;

  assign cpu_tag       = cpu_addr_i[ADDR_W-1 -: TAG_W];
  assign cpu_idx       = cpu_addr_i[OFFSET_W +: INDEX_W];
  assign cpu_sel       = cpu_addr_i[2 +: WORD_SEL_W];
  assign unused_addr_c = ^cpu_addr_i[1:0];

  logic                 rd_valid;
  logic                 rd_dirty;
  logic [TAG_W-1:0]     rd_tag;
  logic [LINE_BITS-1:0] rd_line;

  state_e               state_q, state_d;
  logic [TAG_W-1:0]     req_tag_q, req_tag_d;
  logic [INDEX_W-1:0]   req_idx_q, req_idx_d;
  logic                 mem_enable_q, mem_enable_d;
  logic                 mem_write_q, mem_write_d;
  logic [ADDR_W-1:0]    mem_addr_q, mem_addr_d;
  logic [LINE_BITS-1:0] mem_wdata_q, mem_wdata_d;

  logic idle_c, hit_c, miss_c, fill_we_c, word_we_c;

  assign idle_c    = (state_q == IDLE);
  assign hit_c     = cpu_req_i & rd_valid & (rd_tag == cpu_tag);
  assign miss_c    = idle_c & cpu_req_i & ~hit_c;
  assign fill_we_c = (state_q == FILL) & mem_ack_i;
  assign word_we_c = idle_c & hit_c & cpu_we_i;

  // Stall is combinational so a miss freezes the pipeline in the cycle it is detected.
  assign cpu_stall_o = ~rst_i & (~idle_c | (cpu_req_i & ~hit_c));
  assign cpu_rdata_o = (~rst_i & idle_c & hit_c) ? rd_line[{cpu_sel, 5'b0} +: WORD_W] : '0;

  dcache_sram u_sram (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .rd_idx_i    (cpu_idx),
    .rd_valid_o  (rd_valid),
    .rd_dirty_o  (rd_dirty),
    .rd_tag_o    (rd_tag),
    .rd_line_o   (rd_line),
    .wr_idx_i    (fill_we_c ? req_idx_q : cpu_idx),
    .fill_we_i   (fill_we_c),
    .fill_tag_i  (req_tag_q),
    .fill_line_i (mem_rdata_i),
    .word_we_i   (word_we_c),
    .word_sel_i  (cpu_sel),
    .word_data_i (cpu_wdata_i)
  );

  // Memory-side outputs are computed one state ahead so they are stable from state entry.
  always_comb begin
    state_d      = state_q;
    req_tag_d    = req_tag_q;
    req_idx_d    = req_idx_q;
    mem_enable_d = mem_enable_q;
    mem_write_d  = mem_write_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    unique case (state_q)
      IDLE: begin
        if (miss_c) begin
          req_tag_d    = cpu_tag;
          req_idx_d    = cpu_idx;
          mem_enable_d = 1'b1;
          if (rd_valid && rd_dirty) begin
            state_d     = WRITEBACK;
            mem_write_d = 1'b1;
            mem_addr_d  = line_addr(rd_tag, cpu_idx);
            mem_wdata_d = rd_line;
          end else begin
            state_d     = FILL;
            mem_write_d = 1'b0;
            mem_addr_d  = line_addr(cpu_tag, cpu_idx);
            mem_wdata_d = '0;
          end
        end
      end
      WRITEBACK: begin
        if (mem_ack_i) begin
          state_d     = FILL;
          mem_write_d = 1'b0;
          mem_addr_d  = line_addr(req_tag_q, req_idx_q);
          mem_wdata_d = '0;
        end
      end
      FILL: begin
        if (mem_ack_i) begin
          state_d      = REFILL_DONE;
          mem_enable_d = 1'b0;
          mem_addr_d   = '0;
        end
      end
      REFILL_DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d      = IDLE;
        mem_enable_d = 1'b0;
        mem_write_d  = 1'b0;
        mem_addr_d   = '0;
        mem_wdata_d  = '0;
      end
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= IDLE;
      req_tag_q    <= '0;
      req_idx_q    <= '0;
      mem_enable_q <= 1'b0;
      mem_write_q  <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
    end else begin
      state_q      <= state_d;
      req_tag_q    <= req_tag_d;
      req_idx_q    <= req_idx_d;
      mem_enable_q <= mem_enable_d;
      mem_write_q  <= mem_write_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
    end
  end

  assign mem_enable_o = mem_enable_q;
  assign mem_write_o  = mem_write_q;
  assign mem_addr_o   = mem_addr_q;
  assign mem_wdata_o  = mem_wdata_q;

endmodule

// File: tb/tb_dcache_controller.sv
// Bench for dcache_controller: transparent-memory reference model plus a latency-controlled memory responder.
module tb_dcache_controller;

  logic         clk_i = 1'b0;
  logic         rst_i = 1'b1;
  logic         cpu_req_i = 1'b0;
  logic         cpu_we_i = 1'b0;
  logic [31:0]  cpu_addr_i = '0;
  logic [31:0]  cpu_wdata_i = '0;
  logic [31:0]  cpu_rdata_o;
  logic         cpu_stall_o;
  logic         mem_enable_o;
  logic         mem_write_o;
  logic [31:0]  mem_addr_o;
  logic [255:0] mem_wdata_o;
  logic [255:0] mem_rdata_i = '0;
  logic         mem_ack_i = 1'b0;

  dcache_controller dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .cpu_req_i    (cpu_req_i),
    .cpu_we_i     (cpu_we_i),
    .cpu_addr_i   (cpu_addr_i),
    .cpu_wdata_i  (cpu_wdata_i),
    .cpu_rdata_o  (cpu_rdata_o),
    .cpu_stall_o  (cpu_stall_o),
    .mem_enable_o (mem_enable_o),
    .mem_write_o  (mem_write_o),
    .mem_addr_o   (mem_addr_o),
    .mem_wdata_o  (mem_wdata_o),
    .mem_rdata_i  (mem_rdata_i),
    .mem_ack_i    (mem_ack_i)
  );

  always #5 clk_i = ~clk_i;

  int checks = 0;
  int fails  = 0;

  typedef struct {
    logic         w;
    logic [31:0]  a;
    logic [255:0] d;
  } txn_t;

  txn_t        txq[$];
  int unsigned unstable   = 0;
  int unsigned cyc        = 0;
  int unsigned inject_cyc = 32'hFFFF_FFFF;
  int          lat_wb     = 1;
  int          lat_fill   = 1;

  // Backing memory (word granular, written only by the responder) and architectural view.
  logic [31:0] bw   [int unsigned];
  logic [31:0] arch [int unsigned];
  bit          mv [16];
  bit          md [16];
  logic [22:0] mt [16];

  function automatic logic [31:0] init_word(input logic [31:0] a);
    if (a == 32'h0000_0040) return 32'h1234_5678;
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  function automatic logic [31:0] bmem_rd(input logic [31:0] a);
    if (bw.exists(a)) return bw[a];
    return init_word(a);
  endfunction

  function automatic logic [31:0] arch_rd(input logic [31:0] a);
    if (arch.exists(a)) return arch[a];
    return bmem_rd(a);
  endfunction

  function automatic logic [255:0] bmem_line(input logic [31:0] la);
    logic [255:0] l;
    for (int w = 0; w < 8; w++) l[w*32 +: 32] = bmem_rd(la + 32'(w*4));
    return l;
  endfunction

  function automatic logic [255:0] arch_line(input logic [31:0] la);
    logic [255:0] l;
    for (int w = 0; w < 8; w++) l[w*32 +: 32] = arch_rd(la + 32'(w*4));
    return l;
  endfunction

  // Memory responder: logs each request, checks it stays stable, acks after the chosen latency.
  int   cnt = 0;
  txn_t cur;
  always @(negedge clk_i) begin
    cyc = cyc + 1;
    mem_ack_i = 1'b0;
    mem_rdata_i = '0;
    if (rst_i) begin
      cnt = 0;
    end else if (cyc == inject_cyc) begin
      mem_ack_i = 1'b1;
      mem_rdata_i = {8{32'hBAD0_BAD0}};
    end else if (mem_enable_o) begin
      cnt = cnt + 1;
      if (cnt == 1) begin
        cur.w = mem_write_o;
        cur.a = mem_addr_o;
        cur.d = mem_wdata_o;
        txq.push_back(cur);
      end else if (mem_write_o !== cur.w || mem_addr_o !== cur.a ||
                   (cur.w && mem_wdata_o !== cur.d)) begin
        unstable = unstable + 1;
      end
      if (cnt >= (cur.w ? lat_wb : lat_fill)) begin
        mem_ack_i = 1'b1;
        cnt = 0;
        if (cur.w) begin
          for (int w = 0; w < 8; w++) bw[cur.a + 32'(w*4)] = cur.d[w*32 +: 32];
        end else begin
          mem_rdata_i = bmem_line(cur.a);
        end
      end
    end else begin
      cnt = 0;
    end
  end

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 16; i++) begin
      mv[i] = 1'b0;
      md[i] = 1'b0;
    end
    arch.delete();
  endtask

  // One CPU access: predict from the model, drive until the stall drops, then verify traffic.
  task automatic access(input logic [31:0] addr, input bit we, input logic [31:0] wd,
                        input int lwb, input int lfill, output int n_stall, output logic [31:0] rd);
    logic [3:0]   idx;
    logic [22:0]  tag;
    bit           hit, exp_wb;
    logic [31:0]  wb_a, fill_a, exp_rd;
    logic [255:0] wb_d;
    int           exp_stall, exp_n, t0;
    int unsigned  u0;
    idx       = addr[8:5];
    tag       = addr[31:9];
    hit       = mv[idx] && (mt[idx] == tag);
    exp_wb    = !hit && mv[idx] && md[idx];
    wb_a      = {mt[idx], idx, 5'b0};
    wb_d      = arch_line(wb_a);
    fill_a    = {addr[31:5], 5'b0};
    exp_rd    = arch_rd(addr);
    exp_stall = hit ? 0 : (2 + lfill + (exp_wb ? lwb : 0));
    exp_n     = hit ? 0 : (exp_wb ? 2 : 1);
    lat_wb    = lwb;
    lat_fill  = lfill;
    t0        = txq.size();
    u0        = unstable;
    @(negedge clk_i);
    cpu_req_i   = 1'b1;
    cpu_we_i    = we;
    cpu_addr_i  = addr;
    cpu_wdata_i = wd;
    n_stall = 0;
    #1;
    while (cpu_stall_o !== 1'b0 && n_stall < exp_stall + 20) begin
      n_stall++;
      @(negedge clk_i);
      #1;
    end
    chk("stall_cycles", 256'(n_stall), 256'(exp_stall));
    rd = cpu_rdata_o;
    if (!we) chk("load_data", rd, exp_rd);
    @(posedge clk_i);
    #1 cpu_req_i = 1'b0;
    if (!hit) begin
      mv[idx] = 1'b1;
      md[idx] = 1'b0;
      mt[idx] = tag;
    end
    if (we) begin
      arch[addr] = wd;
      md[idx] = 1'b1;
    end
    chk("txn_count", 256'(txq.size() - t0), 256'(exp_n));
    if (txq.size() - t0 == exp_n && exp_n > 0) begin
      if (exp_wb) begin
        chk("wb_write", txq[t0].w, 1'b1);
        chk("wb_addr", txq[t0].a, wb_a);
        chk("wb_data", txq[t0].d, wb_d);
      end
      chk("fill_write", txq[t0+exp_n-1].w, 1'b0);
      chk("fill_addr", txq[t0+exp_n-1].a, fill_a);
    end
    chk("mem_stable", 256'(unstable - u0), 256'(0));
  endtask

  task automatic idle_chk();
    @(negedge clk_i);
    cpu_req_i = 1'b0;
    #1;
    chk("idle_stall", cpu_stall_o, 1'b0);
    chk("idle_rdata", cpu_rdata_o, 32'h0);
    chk("idle_men", mem_enable_o, 1'b0);
  endtask

  task automatic reset_outputs_chk(input string tagn);
    chk({tagn, "_stall"}, cpu_stall_o, 1'b0);
    chk({tagn, "_men"}, mem_enable_o, 1'b0);
    chk({tagn, "_mwrite"}, mem_write_o, 1'b0);
    chk({tagn, "_maddr"}, mem_addr_o, 32'h0);
    chk({tagn, "_mwdata"}, mem_wdata_o, 256'h0);
    chk({tagn, "_rdata"}, cpu_rdata_o, 32'h0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got no completion, required finish before time limit");
    $fatal(1);
  end

  initial begin
    logic [31:0] rd;
    logic [31:0] a;
    logic [22:0] tags [4];
    int          ns;
    int          t;
    tags = '{23'h0, 23'h1, 23'h2A5, 23'h7F_FFFF};

    repeat (2) @(negedge clk_i);
    #1 reset_outputs_chk("por");
    #1 rst_i = 1'b0;
    model_reset();
    idle_chk();

    // Cold load, 10-cycle fill.
    access(32'h0000_0040, 1'b0, 32'h0, 1, 10, ns, rd);
    chk("cold_stall_lit", 256'(ns), 256'(12));
    chk("cold_rdata_lit", rd, 32'h1234_5678);
    if (txq.size() > 0) begin
      chk("cold_fill_addr_lit", txq[0].a, 32'h0000_0040);
      chk("cold_fill_w_lit", txq[0].w, 1'b0);
    end

    access(32'h0000_0044, 1'b0, 32'h0, 1, 1, ns, rd);
    chk("hit_stall_lit", 256'(ns), 256'(0));

    // Dirty eviction of index 2.
    access(32'h0000_0040, 1'b1, 32'hDEAD_BEEF, 1, 1, ns, rd);
    t = txq.size();
    access(32'h0000_0240, 1'b0, 32'h0, 3, 4, ns, rd);
    chk("evict_stall_lit", 256'(ns), 256'(9));
    if (txq.size() == t + 2) begin
      chk("evict_wb_addr_lit", txq[t].a, 32'h0000_0040);
      chk("evict_wb_word0_lit", txq[t].d[31:0], 32'hDEAD_BEEF);
      chk("evict_fill_addr_lit", txq[t+1].a, 32'h0000_0240);
    end
    access(32'h0000_0040, 1'b0, 32'h0, 2, 2, ns, rd);
    chk("clean_refill_stall_lit", 256'(ns), 256'(4));
    chk("refill_rdata_lit", rd, 32'hDEAD_BEEF);

    // Store miss to a clean line, then dirty eviction of it.
    access(32'h0000_0100, 1'b1, 32'hCAFE_F00D, 1, 3, ns, rd);
    chk("store_miss_stall_lit", 256'(ns), 256'(5));
    access(32'h0000_0100, 1'b0, 32'h0, 1, 1, ns, rd);
    chk("store_miss_rdata_lit", rd, 32'hCAFE_F00D);
    access(32'h0000_0300, 1'b0, 32'h0, 2, 2, ns, rd);
    chk("dirty_evict_stall_lit", 256'(ns), 256'(6));

    // Zero-wait memory.
    access(32'h0000_0800, 1'b0, 32'h0, 1, 1, ns, rd);
    chk("zero_wait_stall_lit", 256'(ns), 256'(3));

    // Reset in the middle of a fill, with a stale ack afterwards.
    lat_fill = 100;
    @(negedge clk_i);
    cpu_req_i  = 1'b1;
    cpu_we_i   = 1'b0;
    cpu_addr_i = 32'h0000_0580;
    repeat (4) @(negedge clk_i);
    #1;
    chk("rfill_men", mem_enable_o, 1'b1);
    chk("rfill_addr", mem_addr_o, 32'h0000_0580);
    chk("rfill_stall", cpu_stall_o, 1'b1);
    #1 rst_i = 1'b1;
    #1 reset_outputs_chk("midrst");
    repeat (2) @(negedge clk_i);
    #2;
    rst_i = 1'b0;
    cpu_req_i = 1'b0;
    inject_cyc = cyc + 2;
    model_reset();
    repeat (4) idle_chk();
    access(32'h0000_0580, 1'b0, 32'h0, 1, 2, ns, rd);
    chk("post_rst_stall_lit", 256'(ns), 256'(4));
    chk("post_rst_rdata", rd, init_word(32'h0000_0580));

    // Randomized traffic over a small set of conflicting lines.
    for (int i = 0; i < 250; i++) begin
      a = {tags[$urandom_range(3)], 4'($urandom_range(3)), 3'($urandom_range(7)), 2'b00};
      access(a, 1'($urandom_range(1)), $urandom, $urandom_range(1, 4), $urandom_range(1, 4), ns, rd);
      if ($urandom_range(3) == 0) idle_chk();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
